demux_reg_1x4: RTL and testbench

- Registered 1-to-4 demultiplexer: the write-side counterpart of the 4:1 output multiplexer used across the memory-game datapath.
- Captures an N-bit input word into one of four holding registers. The target register is chosen either explicitly by SEL or by an internal round-robin write pointer.
- Tracks which registers hold valid data and flags when all four are loaded.
- Typical use: filling the four display/sequence slots that the output mux later reads back.

---
 rtl/demux_reg_1x4.sv | 54 +++++
 tb/tb_demux_reg_1x4.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_reg_1x4.sv
// Registered 1-to-4 demultiplexer: stores a word into one of four holding registers,
// chosen by an explicit select or by a round-robin write pointer.
module demux_reg_1x4 #(
   parameter int N = 7
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic [N-1:0] D,
   input  logic [1:0]   SEL,
   input  logic         load,
   input  logic         push,
   output logic [N-1:0] Q0,
   output logic [N-1:0] Q1,
   output logic [N-1:0] Q2,
   output logic [N-1:0] Q3,
   output logic [3:0]   valid,
   output logic [1:0]   ptr,
   output logic         full,
   output logic         wrap
);

   logic [N-1:0] regs [4];

   // Priority: reset > clear > load > push > hold. A write in a reset/clear cycle is dropped.
   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         // NOTE: only four small registers, so they are cleared directly rather than left uninitialised.
         for (int i = 0; i < 4; i++) regs[i] <= '0;
         valid <= '0;
         ptr   <= '0;
         wrap  <= 1'b0;
      end else if (load) begin
         regs[SEL]  <= D;
         valid[SEL] <= 1'b1;
         wrap       <= 1'b0;
      end else if (push) begin
         regs[ptr]  <= D;
         valid[ptr] <= 1'b1;
         ptr        <= ptr + 2'd1;
         wrap       <= (ptr == 2'd3);
      end else begin
         wrap <= 1'b0;
      end
   end

   assign Q0   = regs[0];
   assign Q1   = regs[1];
   assign Q2   = regs[2];
   assign Q3   = regs[3];
   assign full = &valid;

endmodule

// File: tb/tb_demux_reg_1x4.sv
// Directed bench for demux_reg_1x4: each task drives one scenario and checks outputs inline.
module tb_demux_reg_1x4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic [6:0] D     = '0;
   logic [1:0] SEL   = '0;
   logic       load  = 1'b0;
   logic       push  = 1'b0;
   logic [6:0] Q0, Q1, Q2, Q3;
   logic [3:0] valid;
   logic [1:0] ptr;
   logic       full, wrap;

   int checks   = 0;
   int failures = 0;

   logic [6:0] q [4];
   assign q[0] = Q0;
   assign q[1] = Q1;
   assign q[2] = Q2;
   assign q[3] = Q3;

   demux_reg_1x4 #(.N(7)) dut (
      .clock(clock), .reset(reset), .clear(clear), .D(D), .SEL(SEL),
      .load(load), .push(push), .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
      .valid(valid), .ptr(ptr), .full(full), .wrap(wrap)
   );

   always #5 clock = ~clock;

   // Advance one rising edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic l, input logic p, input logic [1:0] s, input logic [6:0] d);
      load = l;
      push = p;
      SEL  = s;
      D    = d;
      tick();
      load = 1'b0;
      push = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [6:0] exp_q [4];
      exp_q = '{7'h00, 7'h00, 7'h00, 7'h00};
      do_reset();
      repeat (3) tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL reset_q%0d got=%h exp=%h", i, q[i], exp_q[i]);
         end
      end
      checks++;
      if (valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", valid); end
      checks++;
      if (ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", ptr); end
      checks++;
      if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++;
      if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
   endtask

   task automatic test_push_fill();
      logic [6:0] data [4];
      logic [1:0] exp_ptr [4];
      logic       exp_wrap [4];
      data     = '{7'h11, 7'h22, 7'h33, 7'h44};
      exp_ptr  = '{2'd1, 2'd2, 2'd3, 2'd0};
      exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 2'd0, data[i]);
         checks++;
         if (ptr !== exp_ptr[i]) begin
            failures++;
            $display("FAIL fill_ptr step%0d got=%0d exp=%0d", i, ptr, exp_ptr[i]);
         end
         checks++;
         if (wrap !== exp_wrap[i]) begin
            failures++;
            $display("FAIL fill_wrap step%0d got=%b exp=%b", i, wrap, exp_wrap[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q[i] !== data[i]) begin
            failures++;
            $display("FAIL fill_q%0d got=%h exp=%h", i, q[i], data[i]);
         end
      end
      checks++;
      if (valid !== 4'b1111) begin failures++; $display("FAIL fill_valid got=%b exp=1111", valid); end
      checks++;
      if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
      tick();
      checks++;
      if (wrap !== 1'b0) begin failures++; $display("FAIL fill_wrap_pulse_end got=%b exp=0", wrap); end
   endtask

   task automatic test_load_then_push();
      do_reset();
      drive(1'b1, 1'b0, 2'd2, 7'h5A);
      checks++;
      if (Q2 !== 7'h5A) begin failures++; $display("FAIL load_q2 got=%h exp=5a", Q2); end
      checks++;
      if (valid !== 4'b0100) begin failures++; $display("FAIL load_valid got=%b exp=0100", valid); end
      checks++;
      if (ptr !== 2'd0) begin failures++; $display("FAIL load_ptr got=%0d exp=0", ptr); end
      checks++;
      if (full !== 1'b0) begin failures++; $display("FAIL load_full got=%b exp=0", full); end
      drive(1'b0, 1'b1, 2'd0, 7'h01);
      checks++;
      if (Q0 !== 7'h01) begin failures++; $display("FAIL lpush_q0 got=%h exp=01", Q0); end
      checks++;
      if (valid !== 4'b0101) begin failures++; $display("FAIL lpush_valid got=%b exp=0101", valid); end
      checks++;
      if (ptr !== 2'd1) begin failures++; $display("FAIL lpush_ptr got=%0d exp=1", ptr); end
   endtask

   // Continues from test_load_then_push: ptr=1, Q1 still unwritten.
   task automatic test_load_over_push();
      drive(1'b1, 1'b1, 2'd3, 7'h7F);
      checks++;
      if (Q3 !== 7'h7F) begin failures++; $display("FAIL lop_q3 got=%h exp=7f", Q3); end
      checks++;
      if (Q1 !== 7'h00) begin failures++; $display("FAIL lop_q1 got=%h exp=00", Q1); end
      checks++;
      if (ptr !== 2'd1) begin failures++; $display("FAIL lop_ptr got=%0d exp=1", ptr); end
      checks++;
      if (wrap !== 1'b0) begin failures++; $display("FAIL lop_wrap got=%b exp=0", wrap); end
      checks++;
      if (valid !== 4'b1101) begin failures++; $display("FAIL lop_valid got=%b exp=1101", valid); end
   endtask

   task automatic test_clear();
      do_reset();
      drive(1'b0, 1'b1, 2'd0, 7'h0A);
      drive(1'b0, 1'b1, 2'd0, 7'h0B);
      drive(1'b0, 1'b1, 2'd0, 7'h0C);
      drive(1'b0, 1'b1, 2'd0, 7'h0D);
      clear = 1'b1;
      drive(1'b0, 1'b1, 2'd0, 7'h55);
      clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q[i] !== 7'h00) begin
            failures++;
            $display("FAIL clear_q%0d got=%h exp=00", i, q[i]);
         end
      end
      checks++;
      if (valid !== 4'b0000) begin failures++; $display("FAIL clear_valid got=%b exp=0000", valid); end
      checks++;
      if (ptr !== 2'd0) begin failures++; $display("FAIL clear_ptr got=%0d exp=0", ptr); end
      checks++;
      if (full !== 1'b0) begin failures++; $display("FAIL clear_full got=%b exp=0", full); end
      checks++;
      if (wrap !== 1'b0) begin failures++; $display("FAIL clear_wrap got=%b exp=0", wrap); end
   endtask

   task automatic test_overwrite();
      logic [6:0] exp_q [4];
      exp_q = '{7'h66, 7'h22, 7'h33, 7'h44};
      do_reset();
      drive(1'b0, 1'b1, 2'd0, 7'h11);
      drive(1'b0, 1'b1, 2'd0, 7'h22);
      drive(1'b0, 1'b1, 2'd0, 7'h33);
      drive(1'b0, 1'b1, 2'd0, 7'h44);
      drive(1'b0, 1'b1, 2'd0, 7'h66);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL ovw_q%0d got=%h exp=%h", i, q[i], exp_q[i]);
         end
      end
      checks++;
      if (valid !== 4'b1111) begin failures++; $display("FAIL ovw_valid got=%b exp=1111", valid); end
      checks++;
      if (ptr !== 2'd1) begin failures++; $display("FAIL ovw_ptr got=%0d exp=1", ptr); end
      checks++;
      if (full !== 1'b1) begin failures++; $display("FAIL ovw_full got=%b exp=1", full); end
      checks++;
      if (wrap !== 1'b0) begin failures++; $display("FAIL ovw_wrap got=%b exp=0", wrap); end
   endtask

   task automatic test_back_to_back();
      logic exp_w;
      do_reset();
      push = 1'b1;
      for (int k = 0; k < 8; k++) begin
         D = 7'(k + 1);
         tick();
         exp_w = (k % 4 == 3);
         checks++;
         if (wrap !== exp_w) begin
            failures++;
            $display("FAIL b2b_wrap push%0d got=%b exp=%b", k, wrap, exp_w);
         end
      end
      push = 1'b0;
      checks++;
      if (Q3 !== 7'h08) begin failures++; $display("FAIL b2b_q3 got=%h exp=08", Q3); end
      checks++;
      if (Q0 !== 7'h05) begin failures++; $display("FAIL b2b_q0 got=%h exp=05", Q0); end
      tick();
      checks++;
      if (wrap !== 1'b0) begin failures++; $display("FAIL b2b_wrap_idle got=%b exp=0", wrap); end
   endtask

   initial begin
      test_reset();
      test_push_fill();
      test_load_then_push();
      test_load_over_push();
      test_clear();
      test_overwrite();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
